// File: rtl/cpu_pkg.sv
// Shared types and widths for the 10-bit CPU: opcode encoding, fetch FSM
// states and the next-PC select used by the fetch stage.
package cpu_pkg;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 10;

    typedef enum logic [2:0] {
        OPC_RTYPE = 3'b000,
        OPC_MEM   = 3'b001,
        OPC_BR    = 3'b010,
        OPC_LUHW  = 3'b100,
        OPC_LLHW  = 3'b101,
        OPC_ADDI  = 3'b110,
        OPC_END   = 3'b111
    } opcode_t;

    typedef enum logic {
        RUN,
        HALTED
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_REDIR
    } pc_sel_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, decode valid/ready handoff, branch redirect
// and halt status. master = fetch unit, slave = ROM/decode/execute side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
);
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic               id_ready;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic               halted;

    modport master (
        output rom_addr, id_valid, id_instr, id_pc, halted,
        input  rom_data, id_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  rom_addr, id_valid, id_instr, id_pc, halted,
        output rom_data, id_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC mux (hold / increment / redirect).
// Increment wraps modulo 2^ADDR_W silently.
module fetch_pc_reg import cpu_pkg::*; #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  pc_sel_t           sel,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            unique case (sel)
                PC_INC:   pc <= pc + ADDR_W'(1);
                PC_REDIR: pc <= target;
                default:  pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives ROM address from the PC, captures the word into the
// instruction register, handles redirects and halt. Optional perf counters: INSTR_FETCH_PERF_EN.
module instr_fetch_unit import cpu_pkg::*; #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [2:0]        HALT_OPC = 3'b111
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   bus
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [15:0]          fetch_count,
    output logic [15:0]          redirect_count
`endif
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic               halted;
    logic               redir;
    logic               load;
    logic               capture;
    logic               is_halt;
    pc_sel_t            pc_sel;

    assign redir   = (state == RUN) && bus.redirect_valid;
    assign load    = (state == RUN) && (!id_valid || bus.id_ready);
    assign capture = load && !redir;
    assign is_halt = (bus.rom_data[INSTR_W-1 -: 3] == HALT_OPC);

    // Redirect outranks capture, so a halt word seen alongside a redirect is wrong-path.
    always_comb begin
        pc_sel = PC_HOLD;
        if (redir)                    pc_sel = PC_REDIR;
        else if (capture && !is_halt) pc_sel = PC_INC;
    end

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .sel    (pc_sel),
        .target (bus.redirect_target),
        .pc     (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
            halted   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redir) begin
                        id_valid <= 1'b0;
                    end else if (load) begin
                        id_instr <= bus.rom_data;
                        id_pc    <= pc;
                        id_valid <= 1'b1;
                        if (is_halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    // Halt word drains to decode; nothing else is fetched.
                    if (id_valid && bus.id_ready) id_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_addr = pc;
    assign bus.id_valid = id_valid;
    assign bus.id_instr = id_instr;
    assign bus.id_pc    = id_pc;
    assign bus.halted   = halted;

`ifdef INSTR_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (capture && fetch_count != 16'hFFFF)  fetch_count    <= fetch_count + 16'd1;
            if (redir && redirect_count != 16'hFFFF) redirect_count <= redirect_count + 16'd1;
        end
    end
`endif

endmodule
